systolic_weight_feeder: RTL and testbench
=========================================

Name: systolic_weight_feeder

Overview:
- Initiator side of the PE weight-load chain: drives win/wwrite into the top row of a ROWS x COLS systolic array of PEs.
- On a start pulse it fetches ROWS weight words from weight memory, one word per row with COLS lanes of 8 bits.
- It pushes the words down the chain bottom-row-first, waits for the chain to settle, then pulses done.
- Sits between the weight SRAM and the array's top-row win/wwrite inputs.

Parameters:
ROWS, 8, number of PE rows in the chain (words per load); must be >= 2
COLS, 8, number of PE columns; one 8-bit lane per column
ADDR_W, 8, weight memory address width

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  load request pulse; base_addr sampled with it
base_addr  in  ADDR_W  address of row-0 (top row) weight word
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse: load complete, weights stable in all PEs
err_start  out  1  one-cycle pulse: start seen while a load is in progress (ignored)
mem_rd  out  1  weight memory read strobe
mem_addr  out  ADDR_W  weight memory read address
mem_rdata  in  COLS*8  read data; valid exactly 1 cycle after mem_rd
win  out  COLS*8  signed weight lanes to top-row PEs; lane c = bits [8c+7:8c]
wwrite  out  1  weight-shift enable to top-row PEs

Behaviour:
- Reset (async, immediate):
  - Outputs: busy=0, done=0, err_start=0, mem_rd=0, mem_addr=0, wwrite=0, win=0 (see macro).
  - Internal: FSM to IDLE, counters to 0.
  - A reset during any state aborts the load; no done is issued.
- FSM states:
  - IDLE: wait for start.
  - FETCH: ROWS cycles issuing reads.
  - SHIFT: last data beat.
  - DRAIN: ROWS cycles with wwrite=0.
  - DONE: 1 cycle with done=1.
- Cycle timing, with start sampled high in IDLE at edge 0:
  - Cycles 1..ROWS: mem_rd=1, mem_addr = base_addr+ROWS-1-k for k=0..ROWS-1, i.e. the bottom-row word first, descending.
  - Address arithmetic is modulo 2^ADDR_W; wrap is legal.
  - Cycles 2..ROWS+1: win = registered mem_rdata of the previous cycle's read, wwrite=1. These cycles are contiguous with no bubbles, because the PE chain shifts every cycle wwrite is high.
  - Cycles ROWS+2..2*ROWS+1: DRAIN with wwrite=0 and win held at the idle value, so the delayed wwriteout propagates through all rows.
  - Cycle 2*ROWS+2: done=1, busy=0.
  - busy=1 in cycles 1..2*ROWS+1.
- mem_rd and wwrite overlap for ROWS-1 cycles; the SHIFT state covers the final data beat.
- start handling:
  - start while in FETCH/SHIFT/DRAIN: ignored, err_start pulses the next cycle, the load in progress is unaffected.
  - start in DONE: accepted as a new load (back-to-back); FETCH begins next cycle, done still pulses this cycle.
  - start held high across multiple cycles in IDLE: only the first cycle is accepted; subsequent cycles assert err_start.
- mem_rdata is captured only in cycles following mem_rd=1; otherwise it is don't-care and must not reach win.
- The weight word is passed through unmodified; there is no arithmetic on lanes.

Optional Feature:
Macro WFEED_IDLE_PATTERN_EN.
- Defined: whenever wwrite=0 (including reset and DRAIN), every win lane is 8'hAA, matching the PE idle wout marker so that idle bus traffic is recognisable in waveforms.
- Undefined: win is 0 whenever wwrite=0.
- Timing and all other behaviour are identical.

Test Plan:
- ROWS=4, memory[10..13]=rows 0..3 with lane values 0x01..0x04, start with base_addr=10 → required response:
  - mem_addr 13,12,11,10 in cycles 1-4.
  - wwrite=1 cycles 2-5 with win rows 3,2,1,0.
  - done at cycle 10.
  - Array model holds row r weight = word(10+r).
- Wrap: ROWS=4, base_addr=254 (ADDR_W=8) → mem_addr sequence 1,0,255,254; correct weights loaded.
- start pulsed again at cycle 3 of a load → err_start=1 at cycle 4; the load completes unchanged with done at cycle 10; no second load starts.
- Back-to-back: start asserted in the DONE cycle → done=1 that cycle, mem_rd=1 the next cycle, second load completes 2*ROWS+2 cycles after its start.
- Reset asserted at cycle 3 mid-FETCH → all outputs 0 / idle pattern immediately (asynchronously); no done; a new start after reset release loads normally.
- Macro check: with WFEED_IDLE_PATTERN_EN, win=0xAA.. in IDLE and DRAIN; without it, win=0 in those states; the wwrite window is identical in both builds.

Source files
------------

// File: rtl/systolic_weight_feeder_if.sv
// Bundles the feeder's control handshake, weight-memory read port and top-row PE weight bus.
// master = feeder side, slave = environment side (SRAM, array, sequencer).
interface systolic_weight_feeder_if #(
   parameter int ADDR_W = 8,
   parameter int COLS   = 8
);
   logic                start;
   logic [ADDR_W-1:0]   base_addr;
   logic                busy;
   logic                done;
   logic                err_start;
   logic                mem_rd;
   logic [ADDR_W-1:0]   mem_addr;
   logic [COLS*8-1:0]   mem_rdata;
   logic [COLS*8-1:0]   win;
   logic                wwrite;

   modport master (
      input  start, base_addr, mem_rdata,
      output busy, done, err_start, mem_rd, mem_addr, win, wwrite
   );

   modport slave (
      output start, base_addr, mem_rdata,
      input  busy, done, err_start, mem_rd, mem_addr, win, wwrite
   );
endinterface

// File: rtl/systolic_weight_feeder.sv
// Loads ROWS weight words into the systolic PE chain, bottom row first, then drains and pulses done.
// Optional macro WFEED_IDLE_PATTERN_EN: win shows 8'hAA per lane instead of 0 while wwrite is low.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | ROWS cycles of memory reads, addresses descending from base+ROWS-1
// SHIFT | final data beat onto win (no read)
// DRAIN | ROWS cycles with wwrite low so the shift enable ripples through every row
// DONE  | one-cycle done pulse; a start here begins the next load immediately
module systolic_weight_feeder #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int ADDR_W = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   systolic_weight_feeder_if.master bus
);
   localparam int CNT_W = $clog2(ROWS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

`ifdef WFEED_IDLE_PATTERN_EN
   localparam logic [COLS*8-1:0] IDLE_WIN = {COLS{8'hAA}};
`else
   localparam logic [COLS*8-1:0] IDLE_WIN = '0;
`endif

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [ADDR_W-1:0]   base_q, base_nxt;
   logic                err_q, err_nxt;
   logic                active;
   logic                accept;
   logic                wwrite_int;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         base_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         base_q <= base_nxt;
         err_q  <= err_nxt;
      end
   end

   // cnt is a down-counter: in FETCH it is also the row offset of the word being read
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      base_nxt  = base_q;
      active    = (state == FETCH) || (state == SHIFT) || (state == DRAIN);
      accept    = bus.start && ((state == IDLE) || (state == DONE));
      err_nxt   = bus.start && active;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = FETCH;
               cnt_nxt   = CNT_LAST;
               base_nxt  = bus.base_addr;
            end
         end
         FETCH: begin
            if (cnt == '0) state_nxt = SHIFT;
            else           cnt_nxt   = cnt - 1'b1;
         end
         SHIFT: begin
            state_nxt = DRAIN;
            cnt_nxt   = CNT_LAST;
         end
         DRAIN: begin
            if (cnt == '0) state_nxt = DONE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         DONE: begin
            if (accept) begin
               state_nxt = FETCH;
               cnt_nxt   = CNT_LAST;
               base_nxt  = bus.base_addr;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Data arrives one cycle behind its read, so every FETCH cycle but the first carries a beat
   assign wwrite_int    = ((state == FETCH) && (cnt != CNT_LAST)) || (state == SHIFT);

   assign bus.busy      = active;
   assign bus.done      = (state == DONE);
   assign bus.err_start = err_q;
   assign bus.mem_rd    = (state == FETCH);
   assign bus.mem_addr  = (state == FETCH) ? (base_q + ADDR_W'(cnt)) : '0;
   assign bus.wwrite    = wwrite_int;
   // The SRAM output register is the capture stage; gating keeps stale read data off the bus
   assign bus.win       = wwrite_int ? bus.mem_rdata : IDLE_WIN;
endmodule

// File: tb/tb_systolic_weight_feeder.sv
// Directed bench for systolic_weight_feeder with ROWS=4: SRAM model, PE-chain model, cycle checks.
module tb_systolic_weight_feeder;
   localparam int ROWS   = 4;
   localparam int COLS   = 8;
   localparam int ADDR_W = 8;

`ifdef WFEED_IDLE_PATTERN_EN
   localparam logic [63:0] IDLE_WIN = {8{8'hAA}};
`else
   localparam logic [63:0] IDLE_WIN = 64'h0;
`endif
   localparam logic [63:0] JUNK = {8{8'h5C}};

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   systolic_weight_feeder_if #(.ADDR_W(ADDR_W), .COLS(COLS)) bus ();

   systolic_weight_feeder #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [63:0] mem [256];
   logic [63:0] pe  [ROWS];
   int n_asrt = 0;
   int n_fail = 0;

   // SRAM: registered read data, junk when not reading
   always @(posedge clock) bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : JUNK;

   // PE chain: row 0 takes win, every row passes its weight down on wwrite
   always @(posedge clock) begin
      if (bus.wwrite) begin
         for (int r = ROWS - 1; r > 0; r--) pe[r] <= pe[r-1];
         pe[0] <= bus.win;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},   64'(bus.busy),      64'h0);
      chk({tag, "_done"},   64'(bus.done),      64'h0);
      chk({tag, "_err"},    64'(bus.err_start), 64'h0);
      chk({tag, "_mem_rd"}, 64'(bus.mem_rd),    64'h0);
      chk({tag, "_addr"},   64'(bus.mem_addr),  64'h0);
      chk({tag, "_wwrite"}, 64'(bus.wwrite),    64'h0);
      chk({tag, "_win"},    bus.win,            IDLE_WIN);
   endtask

   // Caller raises start/base_addr before the call; the next rising edge is edge 0.
   // extra>0 raises start again during cycle 'extra'; chain starts another load in DONE.
   task automatic run_load(input string tag, input logic [7:0] base, input int extra,
                           input bit chain, input logic [7:0] next_base);
      logic [7:0] a;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 2*ROWS + 2; c++) begin
         bit ex_rd, ex_ww;
         ex_rd = (c >= 1) && (c <= ROWS);
         ex_ww = (c >= 2) && (c <= ROWS + 1);
         chk($sformatf("%s_c%0d_mem_rd", tag, c), 64'(bus.mem_rd), 64'(ex_rd));
         a = 8'(base + ROWS - c);
         chk($sformatf("%s_c%0d_addr", tag, c), 64'(bus.mem_addr), ex_rd ? 64'(a) : 64'h0);
         chk($sformatf("%s_c%0d_wwrite", tag, c), 64'(bus.wwrite), 64'(ex_ww));
         a = 8'(base + ROWS + 1 - c);
         chk($sformatf("%s_c%0d_win", tag, c), bus.win, ex_ww ? mem[a] : IDLE_WIN);
         chk($sformatf("%s_c%0d_busy", tag, c), 64'(bus.busy), 64'(c <= 2*ROWS + 1));
         chk($sformatf("%s_c%0d_done", tag, c), 64'(bus.done), 64'(c == 2*ROWS + 2));
         chk($sformatf("%s_c%0d_err", tag, c), 64'(bus.err_start), 64'(extra > 0 && c == extra + 1));
         if (extra > 0 && c == extra) begin
            bus.start     = 1'b1;
            bus.base_addr = 8'd99;
         end
         if (extra > 0 && c == extra + 1) bus.start = 1'b0;
         if (chain && c == 2*ROWS + 2) begin
            bus.start     = 1'b1;
            bus.base_addr = next_base;
         end
         if (c < 2*ROWS + 2 || chain) begin
            if (c < 2*ROWS + 2) tick();
         end else begin
            tick();
         end
      end
   endtask

   task automatic chk_array(input string tag, input logic [7:0] base);
      for (int r = 0; r < ROWS; r++)
         chk($sformatf("%s_pe%0d", tag, r), pe[r], mem[8'(base + r)]);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = {8{8'(a)}} ^ 64'h0706050403020100;
      for (int r = 0; r < ROWS; r++) mem[10 + r] = {8{8'(r + 1)}};
      mem[254] = {8{8'h11}};
      mem[255] = {8{8'h22}};
      mem[0]   = {8{8'h33}};
      mem[1]   = {8{8'h44}};

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      tick();
      chk_idle_outputs("reset");
      tick();
      reset = 1'b0;
      tick();
      chk_idle_outputs("idle");

      // Basic load: bottom row first from base 10; weights are hand values 0x01..0x04
      bus.start = 1'b1; bus.base_addr = 8'd10;
      run_load("basic", 8'd10, 0, 1'b0, 8'd0);
      chk("basic_pe0", pe[0], {8{8'h01}});
      chk("basic_pe1", pe[1], {8{8'h02}});
      chk("basic_pe2", pe[2], {8{8'h03}});
      chk("basic_pe3", pe[3], {8{8'h04}});

      // Address wrap: 1,0,255,254
      tick();
      bus.start = 1'b1; bus.base_addr = 8'd254;
      run_load("wrap", 8'd254, 0, 1'b0, 8'd0);
      chk("wrap_pe0", pe[0], {8{8'h11}});
      chk("wrap_pe1", pe[1], {8{8'h22}});
      chk("wrap_pe2", pe[2], {8{8'h33}});
      chk("wrap_pe3", pe[3], {8{8'h44}});

      // Stray start mid-load: err one cycle later, load unchanged, no second load
      tick();
      bus.start = 1'b1; bus.base_addr = 8'd40;
      run_load("busy_start", 8'd40, 3, 1'b0, 8'd0);
      chk_array("busy_start", 8'd40);
      tick();
      chk_idle_outputs("after_busy_start");

      // start held two cycles in IDLE: second cycle reported as error
      bus.start = 1'b1; bus.base_addr = 8'd60;
      run_load("held_start", 8'd60, 1, 1'b0, 8'd0);
      chk_array("held_start", 8'd60);
      tick();

      // Back-to-back: start in DONE launches the next load immediately
      bus.start = 1'b1; bus.base_addr = 8'd10;
      run_load("b2b_first", 8'd10, 0, 1'b1, 8'd80);
      run_load("b2b_second", 8'd80, 0, 1'b0, 8'd0);
      chk_array("b2b_second", 8'd80);
      tick();
      chk_idle_outputs("after_b2b");

      // Reset mid-FETCH: outputs drop without a clock edge, no done follows
      bus.start = 1'b1; bus.base_addr = 8'd10;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      chk("pre_reset_mem_rd", 64'(bus.mem_rd), 64'h1);
      chk("pre_reset_wwrite", 64'(bus.wwrite), 64'h1);
      #1 reset = 1'b1;
      #1 chk_idle_outputs("async_reset");
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 2*ROWS + 4; c++) begin
         tick();
         chk($sformatf("post_reset_c%0d_done", c), 64'(bus.done), 64'h0);
         chk($sformatf("post_reset_c%0d_busy", c), 64'(bus.busy), 64'h0);
      end
      bus.start = 1'b1; bus.base_addr = 8'd120;
      run_load("after_reset", 8'd120, 0, 1'b0, 8'd0);
      chk_array("after_reset", 8'd120);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
